// File: rtl/instr_encoder.sv
// Packs decoded instruction fields into MIPS words and streams them to instruction memory.
// Latency 1 cycle; one output register, in_ready = !out_valid || out_ready while loading.
module instr_encoder #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic [ADDR_W:0]   count,
  output logic              err,
  output logic              done
);

  localparam int CNT_W = ADDR_W + 1;

  localparam logic [2:0] K_R   = 3'd0;
  localparam logic [2:0] K_LW  = 3'd1;
  localparam logic [2:0] K_SW  = 3'd2;
  localparam logic [2:0] K_BEQ = 3'd3;
  localparam logic [2:0] K_J   = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [CNT_W-1:0]    count_q;
  logic [CNT_W-1:0]    count_d;
  logic [31:0]         word_q;
  logic [31:0]         word_d;
  logic [ADDR_W-1:0]   out_addr_q;
  logic                out_valid_q;
  logic                err_q;
  logic                done_q;
  logic                legal;
  logic                accept;
  logic                take;
  logic                last;

  always_comb begin
    word_d = 32'd0;
    legal  = 1'b1;
    case (in_kind)
      K_R:     word_d = {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct};
      K_LW:    word_d = {6'b100011, in_rs, in_rt, in_imm};
      K_SW:    word_d = {6'b101011, in_rs, in_rt, in_imm};
      K_BEQ:   word_d = {6'b000100, in_rs, in_rt, in_imm};
      K_J:     word_d = {6'b000010, in_target};
      default: legal  = 1'b0;
    endcase
  end

  assign in_ready = (state_q == LOAD) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign take     = accept && legal;
  assign count_d  = count_q + 1'b1;
  assign last     = take && (count_d == CNT_W'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= ADDR_W'(BASE);
      count_q     <= '0;
      word_q      <= '0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= LOAD;
            addr_q  <= ADDR_W'(BASE);
            count_q <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        LOAD: begin
          if (take) begin
            word_q      <= word_d;
            out_addr_q  <= addr_q;
            out_valid_q <= 1'b1;
            addr_q      <= addr_q + 1'b1;
            count_q     <= count_d;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
          // Illegal bundles are swallowed without consuming an address.
          if (accept && !legal) err_q <= 1'b1;
          if (finish || last) state_q <= DRAIN;
        end
        DRAIN: begin
          if (!out_valid_q || out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= DONE;
            done_q      <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_word  = word_q;
  assign out_addr  = out_addr_q;
  assign count     = count_q;
  assign err       = err_q;
  assign done      = done_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: default instance (BASE 0) plus a small wrapping instance.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst_b_n = 1'b0;
  logic        start = 1'b0;
  logic        finish = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  in_kind = '0;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [5:0]  in_funct = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;
  logic        out_ready = 1'b1;

  logic        a_in_ready, a_out_valid, a_err, a_done;
  logic [31:0] a_out_word;
  logic [7:0]  a_out_addr;
  logic [8:0]  a_count;

  logic        b_in_ready, b_out_valid, b_err, b_done;
  logic [31:0] b_out_word;
  logic [7:0]  b_out_addr;
  logic [8:0]  b_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(8), .DEPTH(256), .BASE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_word(a_out_word),
    .out_addr(a_out_addr), .count(a_count), .err(a_err), .done(a_done)
  );

  instr_encoder #(.ADDR_W(8), .DEPTH(4), .BASE(254)) dut_b (
    .clk(clk), .rst_n(rst_b_n), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_word(b_out_word),
    .out_addr(b_out_addr), .count(b_count), .err(b_err), .done(b_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [5:0] fn, input logic [15:0] imm,
                      input logic [25:0] tgt);
    in_valid  = 1'b1;
    in_kind   = k;
    in_rs     = rs;
    in_rt     = rt;
    in_rd     = rd;
    in_shamt  = 5'd0;
    in_funct  = fn;
    in_imm    = imm;
    in_target = tgt;
  endtask

  task automatic chk_a(input string tag, input logic [31:0] w, input logic [7:0] ad,
                       input logic [8:0] cnt);
    chk({tag, "_vld"}, 32'(a_out_valid), 32'd1);
    chk({tag, "_word"}, a_out_word, w);
    chk({tag, "_addr"}, 32'(a_out_addr), 32'(ad));
    chk({tag, "_cnt"}, 32'(a_count), 32'(cnt));
  endtask

  initial begin
    tick();
    chk("rst_vld", 32'(a_out_valid), 32'd0);
    chk("rst_word", a_out_word, 32'd0);
    chk("rst_addr", 32'(a_out_addr), 32'd0);
    chk("rst_cnt", 32'(a_count), 32'd0);
    chk("rst_err", 32'(a_err), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_rdy", 32'(a_in_ready), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_rdy", 32'(a_in_ready), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;

    // First word and back-to-back stream
    send(3'd1, 5'd9, 5'd8, 5'd0, 6'd0, 16'd4, 26'd0);
    #1 chk("lw_rdy", 32'(a_in_ready), 32'd1);
    tick();
    chk_a("lw", 32'h8D280004, 8'd0, 9'd1);
    send(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'd0, 26'd0);
    #1 chk("r_rdy", 32'(a_in_ready), 32'd1);
    tick();
    chk_a("r", 32'h00221820, 8'd1, 9'd2);
    send(3'd2, 5'd6, 5'd5, 5'd0, 6'd0, 16'd8, 26'd0);
    #1 chk("sw_rdy", 32'(a_in_ready), 32'd1);
    tick();
    chk_a("sw", 32'hACC50008, 8'd2, 9'd3);
    send(3'd3, 5'd1, 5'd2, 5'd0, 6'd0, 16'hFFFF, 26'd0);
    #1 chk("beq_rdy", 32'(a_in_ready), 32'd1);
    tick();
    chk_a("beq", 32'h1022FFFF, 8'd3, 9'd4);
    send(3'd4, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10);
    #1 chk("j_rdy", 32'(a_in_ready), 32'd1);
    tick();
    chk_a("j", 32'h08000010, 8'd4, 9'd5);

    // Backpressure: J word must stay put, next bundle waits
    out_ready = 1'b0;
    send(3'd1, 5'd1, 5'd2, 5'd0, 6'd0, 16'h10, 26'd0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_rdy", 32'(a_in_ready), 32'd0);
      tick();
      chk_a("bp_hold", 32'h08000010, 8'd4, 9'd5);
    end
    out_ready = 1'b1;
    #1 chk("bp_rel_rdy", 32'(a_in_ready), 32'd1);
    tick();
    chk_a("bp_resume", 32'h8C220010, 8'd5, 9'd6);

    // Illegal kind: no word, no address consumed, sticky err
    send(3'd6, 5'd1, 5'd1, 5'd1, 6'd1, 16'd1, 26'd1);
    tick();
    chk("ill_vld", 32'(a_out_valid), 32'd0);
    chk("ill_err", 32'(a_err), 32'd1);
    chk("ill_cnt", 32'(a_count), 32'd6);
    send(3'd2, 5'd6, 5'd5, 5'd0, 6'd0, 16'd8, 26'd0);
    tick();
    chk_a("post_ill", 32'hACC50008, 8'd6, 9'd7);
    in_valid = 1'b0;
    tick();
    chk("idle_vld", 32'(a_out_valid), 32'd0);
    chk("err_sticky", 32'(a_err), 32'd1);

    // Finish together with a legal accept
    send(3'd1, 5'd9, 5'd8, 5'd0, 6'd0, 16'd4, 26'd0);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    in_valid = 1'b0;
    chk_a("fin_word", 32'h8D280004, 8'd7, 9'd8);
    chk("drain_rdy", 32'(a_in_ready), 32'd0);
    tick();
    chk("fin_done", 32'(a_done), 32'd1);
    chk("fin_vld", 32'(a_out_valid), 32'd0);
    chk("fin_cnt", 32'(a_count), 32'd8);
    chk("fin_err", 32'(a_err), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_err", 32'(a_err), 32'd0);
    chk("restart_cnt", 32'(a_count), 32'd0);
    chk("restart_done", 32'(a_done), 32'd0);

    // Reset while a word is pending
    send(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'd0, 26'd0);
    tick();
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk_a("pre_rst", 32'h00221820, 8'd0, 9'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst_vld", 32'(a_out_valid), 32'd0);
    chk("mrst_word", a_out_word, 32'd0);
    chk("mrst_addr", 32'(a_out_addr), 32'd0);
    chk("mrst_cnt", 32'(a_count), 32'd0);
    chk("mrst_rdy", 32'(a_in_ready), 32'd0);
    out_ready = 1'b1;

    // DEPTH=4, BASE=254 instance: address wrap and auto drain
    rst_b_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(3'd1, 5'd9, 5'd8, 5'd0, 6'd0, 16'(i), 26'd0);
      #1 chk("b_rdy", 32'(b_in_ready), 32'd1);
      tick();
      chk("b_vld", 32'(b_out_valid), 32'd1);
      chk("b_word", b_out_word, 32'h8D280000 | 32'(i));
      chk("b_addr", 32'(b_out_addr), 32'((254 + i) % 256));
    end
    chk("b_cnt4", 32'(b_count), 32'd4);
    chk("b_drain_rdy", 32'(b_in_ready), 32'd0);
    in_valid = 1'b0;
    tick();
    chk("b_done", 32'(b_done), 32'd1);
    chk("b_done_cnt", 32'(b_count), 32'd4);
    chk("b_done_vld", 32'(b_out_valid), 32'd0);
    chk("b_done_rdy", 32'(b_in_ready), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
